fft_frame_loader: RTL

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

---
 rtl/fft_frame_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding an FFT core.
// Samples fill one bank (optionally in bit-reversed slot order) while the other bank is presented.
module fft_frame_loader #(
  parameter int N      = 16,
  parameter int POINTS = 32,
  parameter int BITREV = 1
) (
  input  logic                      clk2,
  input  logic                      rst,
  input  logic [N-1:0]              s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [N*POINTS-1:0]       frame_data,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic                      err_len,
  output logic [$clog2(POINTS):0]   fill_cnt,
  output logic                      o_dbg_wr_state,
  output logic                      o_dbg_rd_state
);

  localparam int AW = $clog2(POINTS);

  typedef enum logic {WR_FILL  = 1'b0, WR_STALL   = 1'b1} wr_state_t;
  typedef enum logic {RD_EMPTY = 1'b0, RD_PRESENT = 1'b1} rd_state_t;

  // Handshakes: a sample moves when s_valid & s_ready on a rising edge; a frame
  // moves when frame_valid & frame_ready on a rising edge. Neither valid may
  // depend on its ready, and ready alone never changes state.

  logic [N-1:0]  r_mem [2][POINTS];
  logic [1:0]    r_full;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [AW:0]   r_fill;
  logic          r_err_len;
  wr_state_t     r_wr_state;
  rd_state_t     r_rd_state;

  logic          w_accept;
  logic          w_is_last_k;
  logic          w_commit;
  logic          w_early;
  logic          w_err;
  logic          w_release;
  logic [AW-1:0] w_k;
  logic [AW-1:0] w_slot;
  logic [1:0]    w_full_nxt;
  logic          w_wr_ptr_nxt;
  logic          w_rd_ptr_nxt;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) begin
      r[b] = v[AW-1-b];
    end
    return r;
  endfunction

  assign s_ready     = ~r_full[r_wr_ptr];
  assign frame_valid = (r_rd_state == RD_PRESENT);
  assign err_len     = r_err_len;
  assign fill_cnt    = r_fill;

  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state;

  assign w_accept  = s_valid & s_ready;
  assign w_release = frame_valid & frame_ready;
  assign w_k       = r_fill[AW-1:0];
  assign w_slot    = (BITREV != 0) ? f_bitrev(w_k) : w_k;

  // fill_cnt never exceeds POINTS-1, so the low bits being all ones marks the final slot.
  assign w_is_last_k = &r_fill[AW-1:0];
  assign w_commit    = w_accept & w_is_last_k;
  assign w_early     = w_accept & s_last & ~w_is_last_k;
  assign w_err       = w_early | (w_commit & ~s_last);

  assign w_wr_ptr_nxt = r_wr_ptr ^ w_commit;
  assign w_rd_ptr_nxt = r_rd_ptr ^ w_release;

  // A commit needs an empty write bank and a release needs a full read bank,
  // so when both happen on one edge they always touch different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit) begin
      w_full_nxt[r_wr_ptr] = 1'b1;
    end
    if (w_release) begin
      w_full_nxt[r_rd_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      r_full     <= 2'b00;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fill     <= '0;
      r_err_len  <= 1'b0;
      r_wr_state <= WR_FILL;
      r_rd_state <= RD_EMPTY;
    end else begin
      r_full    <= w_full_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_err_len <= w_err;
      if (w_commit || w_early) begin
        r_fill <= '0;
      end else if (w_accept) begin
        r_fill <= r_fill + {{AW{1'b0}}, 1'b1};
      end
      r_wr_state <= w_full_nxt[w_wr_ptr_nxt] ? WR_STALL : WR_FILL;
      r_rd_state <= w_full_nxt[w_rd_ptr_nxt] ? RD_PRESENT : RD_EMPTY;
    end
  end

  // Bank storage carries no reset; a bank is only meaningful once its full flag is set.
  always_ff @(posedge clk2) begin
    if (w_accept) begin
      r_mem[r_wr_ptr][w_slot] <= s_data;
    end
  end

  for (genvar gi = 0; gi < POINTS; gi++) begin : g_slot
    assign frame_data[gi*N +: N] = r_mem[r_rd_ptr][gi];
  end

endmodule
